fsk_zc_demod: RTL and testbench

//  Parametrised 2FSK demodulator: slices the sampled carrier with a hysteresis comparator, counts

---
 rtl/fsk_pkg.sv | 29 ++
 rtl/fsk_hyst_slicer.sv | 54 +++++
 rtl/fsk_zc_demod.sv | 135 +++++++++++++
 tb/tb_fsk_zc_demod.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsk_pkg.sv
// ============================================================================
// fsk_pkg : shared types and constant helpers for the FSK zero-crossing demod
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package fsk_pkg;

  typedef enum logic [0:0] {
    ACQ = 1'b0,
    RUN = 1'b1
  } fsk_state_e;

  // Offset-binary midpoint for a given sample width.
  function automatic int fsk_mid(input int data_w);
    return 1 << (data_w - 1);
  endfunction

  // Bits needed to index n entries, never less than one.
  function automatic int fsk_clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fsk_hyst_slicer.sv
// ============================================================================
// fsk_hyst_slicer : hysteresis comparator with sign-change (crossing) strobe
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fsk_hyst_slicer
  import fsk_pkg::*;
#(
  parameter int DATA_W = 11,
  parameter int HYST   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              en_i,
  output logic              sign_o,
  output logic              cross_o
);

  localparam int MID = fsk_mid(DATA_W);
  localparam int HI  = MID + HYST;
  localparam int LO  = MID - HYST;

  int   w_samp;
  logic sign_q;
  logic sign_d;

  assign w_samp = int'(32'(sample_i));

  // Inside the dead band the previous decision is held.
  always_comb begin
    sign_d = sign_q;
    if (w_samp >= HI) begin
      sign_d = 1'b1;
    end else if (w_samp <= LO) begin
      sign_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q <= 1'b0;
    end else if (en_i) begin
      sign_q <= sign_d;
    end
  end

  assign sign_o  = sign_q;
  assign cross_o = en_i & (sign_d != sign_q);

endmodule

`default_nettype wire

// File: rtl/fsk_zc_demod.sv
// ============================================================================
// fsk_zc_demod : 2FSK demodulator counting zero crossings per symbol window
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module fsk_zc_demod
  import fsk_pkg::*;
#(
  parameter int DATA_W  = 11,
  parameter int SYM_LEN = 2048,
  parameter int HYST    = 16,
  parameter int THRESH  = 6,
  parameter int ZC_MIN  = 2,
  parameter int ZC_MAX  = 64,
  parameter int INVERT  = 1,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_i,
  input  logic              sample_vld_i,
  input  logic              sym_sync_i,
  output logic              bit_out_o,
  output logic              bit_vld_o,
  output logic [CNT_W-1:0]  zc_cnt_o,
  output logic              bad_sym_o
);

  localparam int               IDX_W = fsk_clog2(SYM_LEN);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(SYM_LEN - 1);

  fsk_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] zc_q, zc_d;
  logic             bit_q, bit_d;
  logic             vld_q, vld_d;
  logic             bad_q, bad_d;

  logic             w_en;
  logic             w_sign;
  logic             w_cross;
  logic [CNT_W-1:0] w_final;
  logic [31:0]      w_final32;

  // A sync pulse in RUN discards the coincident sample, so the slicer must not see it.
  assign w_en = sample_vld_i & ~(sym_sync_i & (state_q == RUN));

  fsk_hyst_slicer #(
    .DATA_W (DATA_W),
    .HYST   (HYST)
  ) u_slicer (
    .clk      (clk),
    .rst      (rst),
    .sample_i (sample_i),
    .en_i     (w_en),
    .sign_o   (w_sign),
    .cross_o  (w_cross)
  );

  assign w_final   = (w_cross && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  assign w_final32 = 32'(w_final);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    zc_d    = zc_q;
    bit_d   = bit_q;
    bad_d   = bad_q;
    vld_d   = 1'b0;
    case (state_q)
      ACQ: begin
        if (sym_sync_i) begin
          idx_d = '0;
        end
        if (sample_vld_i) begin
          idx_d   = idx_d + IDX_W'(1);
          state_d = RUN;
        end
      end
      RUN: begin
        if (sym_sync_i) begin
          idx_d = '0;
          cnt_d = '0;
        end else if (sample_vld_i) begin
          if (idx_q == LAST) begin
            idx_d = '0;
            cnt_d = '0;
            zc_d  = w_final;
            bit_d = (w_final32 > THRESH) ^ (INVERT != 0);
            bad_d = (w_final32 < ZC_MIN) || (w_final32 > ZC_MAX);
            vld_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            cnt_d = w_final;
          end
        end
      end
      default: state_d = ACQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACQ;
      idx_q   <= '0;
      cnt_q   <= '0;
      zc_q    <= '0;
      bit_q   <= 1'b0;
      vld_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      zc_q    <= zc_d;
      bit_q   <= bit_d;
      vld_q   <= vld_d;
      bad_q   <= bad_d;
    end
  end

  assign bit_out_o = bit_q;
  assign bit_vld_o = vld_q;
  assign zc_cnt_o  = zc_q;
  assign bad_sym_o = bad_q;

  logic w_unused;
  assign w_unused = w_sign;

endmodule

`default_nettype wire

// File: tb/tb_fsk_zc_demod.sv
// ============================================================================
// tb_fsk_zc_demod : scoreboard bench for fsk_zc_demod (CNT_W=8 and CNT_W=4)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsk_zc_demod;

  localparam int MID  = 1024;
  localparam int HYST = 16;
  localparam int SYM  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] sample = 11'(MID);
  logic        vld = 1'b0;
  logic        sync = 1'b0;

  logic       bo8, bv8, bad8;
  logic [7:0] zc8;
  logic       bo4, bv4, bad4;
  logic [3:0] zc4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int   cyc;
    int   zc;
    logic bo;
    logic bad;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];

  // Reference model state
  logic m_acq  = 1'b1;
  logic m_sign = 1'b0;
  int   m_idx  = 0;
  int   m_c8   = 0;
  int   m_c4   = 0;
  int   n      = 0;

  fsk_zc_demod #(
    .DATA_W(11), .SYM_LEN(SYM), .HYST(HYST), .THRESH(6),
    .ZC_MIN(2), .ZC_MAX(64), .INVERT(1), .CNT_W(8)
  ) u_dut (
    .clk(clk), .rst(rst), .sample_i(sample), .sample_vld_i(vld), .sym_sync_i(sync),
    .bit_out_o(bo8), .bit_vld_o(bv8), .zc_cnt_o(zc8), .bad_sym_o(bad8)
  );

  fsk_zc_demod #(
    .DATA_W(11), .SYM_LEN(SYM), .HYST(HYST), .THRESH(6),
    .ZC_MIN(2), .ZC_MAX(64), .INVERT(1), .CNT_W(4)
  ) u_sat (
    .clk(clk), .rst(rst), .sample_i(sample), .sample_vld_i(vld), .sym_sync_i(sync),
    .bit_out_o(bo4), .bit_vld_o(bv4), .zc_cnt_o(zc4), .bad_sym_o(bad4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic slice(input int s, input logic prev);
    if (s >= MID + HYST) return 1'b1;
    if (s <= MID - HYST) return 1'b0;
    return prev;
  endfunction

  function automatic exp_t mk(input int c, input int at);
    exp_t e;
    e.cyc = at;
    e.zc  = c;
    e.bo  = (c > 6) ? 1'b0 : 1'b1;
    e.bad = (c < 2) || (c > 64);
    return e;
  endfunction

  task automatic model_step(input int s, input logic v, input logic sy, input logic r);
    logic ns;
    if (r) begin
      m_acq = 1'b1; m_sign = 1'b0; m_idx = 0; m_c8 = 0; m_c4 = 0;
    end else if (m_acq) begin
      if (sy) m_idx = 0;
      if (v) begin
        m_sign = slice(s, m_sign);
        m_idx  = m_idx + 1;
        m_acq  = 1'b0;
      end
    end else if (sy) begin
      m_idx = 0; m_c8 = 0; m_c4 = 0;
    end else if (v) begin
      ns = slice(s, m_sign);
      if (ns != m_sign) begin
        if (m_c8 < 255) m_c8++;
        if (m_c4 < 15) m_c4++;
      end
      m_sign = ns;
      if (m_idx == SYM - 1) begin
        q8.push_back(mk(m_c8, cyc + 1));
        q4.push_back(mk(m_c4, cyc + 1));
        m_idx = 0; m_c8 = 0; m_c4 = 0;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic drive(input int s, input logic v, input logic sy);
    sample = 11'(s);
    vld    = v;
    sync   = sy;
    model_step(s, v, sy, rst);
    @(posedge clk);
    #1;
  endtask

  function automatic int tone(input int idx, input int per);
    real ph;
    ph = 2.0 * 3.14159265358979 * (real'(idx) + 0.5) / real'(per);
    return MID + int'($rtoi(500.0 * $sin(ph)));
  endfunction

  // Scoreboard: every bit_vld pulse must match the oldest pending decision.
  always @(negedge clk) begin
    if (bv8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL sb8_unexpected cyc=%0d zc=%0d", cyc, zc8);
      end else begin
        exp_t e;
        e = q8.pop_front();
        if (e.cyc != cyc || int'(zc8) != e.zc || bo8 !== e.bo || bad8 !== e.bad) begin
          errors++;
          $display("FAIL sb8 got cyc=%0d zc=%0d bit=%b bad=%b exp cyc=%0d zc=%0d bit=%b bad=%b",
                   cyc, zc8, bo8, bad8, e.cyc, e.zc, e.bo, e.bad);
        end
      end
    end else if (q8.size() > 0 && q8[0].cyc <= cyc) begin
      checks++;
      errors++;
      $display("FAIL sb8_missing exp cyc=%0d got none at cyc=%0d", q8[0].cyc, cyc);
      void'(q8.pop_front());
    end
    if (bv4) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL sb4_unexpected cyc=%0d zc=%0d", cyc, zc4);
      end else begin
        exp_t e;
        e = q4.pop_front();
        if (e.cyc != cyc || int'(zc4) != e.zc || bo4 !== e.bo || bad4 !== e.bad) begin
          errors++;
          $display("FAIL sb4 got cyc=%0d zc=%0d bit=%b bad=%b exp cyc=%0d zc=%0d bit=%b bad=%b",
                   cyc, zc4, bo4, bad4, e.cyc, e.zc, e.bo, e.bad);
        end
      end
    end else if (q4.size() > 0 && q4[0].cyc <= cyc) begin
      checks++;
      errors++;
      $display("FAIL sb4_missing exp cyc=%0d got none at cyc=%0d", q4[0].cyc, cyc);
      void'(q4.pop_front());
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    drive(MID, 1'b0, 1'b0);
    drive(MID, 1'b0, 1'b0);
    rst = 1'b0;
    n = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bo8, bv8, zc8, bad8, bo4, bv4, zc4, bad4} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %b%b%0d%b %b%b%0d%b exp all 0",
               bo8, bv8, zc8, bad8, bo4, bv4, zc4, bad4);
    end
  endtask

  task automatic test_tone(input int per, input int exp_zc, input logic exp_bit);
    do_reset();
    for (int i = 0; i < 2 * SYM; i++) begin
      drive(tone(n, per), 1'b1, 1'b0);
      n++;
    end
    checks++;
    if (bv8 !== 1'b1 || int'(zc8) != exp_zc || bo8 !== exp_bit || bad8 !== 1'b0) begin
      errors++;
      $display("FAIL tone_per%0d got vld=%b zc=%0d bit=%b bad=%b exp 1 %0d %b 0",
               per, bv8, zc8, bo8, bad8, exp_zc, exp_bit);
    end
  endtask

  task automatic test_noise();
    do_reset();
    for (int i = 0; i < 2 * SYM; i++) begin
      drive(MID - 10 + int'($urandom_range(0, 20)), 1'b1, 1'b0);
    end
    checks++;
    if (bv8 !== 1'b1 || zc8 !== 8'd0 || bad8 !== 1'b1 || bo8 !== 1'b1) begin
      errors++;
      $display("FAIL noise got vld=%b zc=%0d bad=%b bit=%b exp 1 0 1 1", bv8, zc8, bad8, bo8);
    end
  endtask

  task automatic test_vld_gaps();
    do_reset();
    while (n < 2 * SYM) begin
      drive(tone(n, 8), 1'b1, 1'b0);
      n++;
      if (n < 2 * SYM) drive(MID + 300, 1'b0, 1'b0);
    end
    checks++;
    if (bv8 !== 1'b1 || zc8 !== 8'd16 || bo8 !== 1'b0) begin
      errors++;
      $display("FAIL vld_gaps got vld=%b zc=%0d bit=%b exp 1 16 0", bv8, zc8, bo8);
    end
    drive(MID + 300, 1'b0, 1'b0);
    checks++;
    if (bv8 !== 1'b0 || zc8 !== 8'd16) begin
      errors++;
      $display("FAIL vld_gaps_hold got vld=%b zc=%0d exp 0 16", bv8, zc8);
    end
  endtask

  task automatic test_sym_sync();
    do_reset();
    for (int i = 0; i < 30; i++) begin
      drive(tone(n, 8), 1'b1, 1'b0);
      n++;
    end
    drive(tone(n, 8), 1'b1, 1'b1);
    n++;
    for (int i = 0; i < 63; i++) begin
      drive(tone(n, 8), 1'b1, 1'b0);
      n++;
    end
    checks++;
    if (bv8 !== 1'b0) begin
      errors++;
      $display("FAIL sync_early got vld=%b exp 0", bv8);
    end
    drive(tone(n, 8), 1'b1, 1'b0);
    n++;
    checks++;
    if (bv8 !== 1'b1 || zc8 !== 8'd16) begin
      errors++;
      $display("FAIL sync_decision got vld=%b zc=%0d exp 1 16", bv8, zc8);
    end
    // Sync coinciding with the window's last sample suppresses the decision.
    for (int i = 0; i < 63; i++) begin
      drive(tone(n, 8), 1'b1, 1'b0);
      n++;
    end
    drive(tone(n, 8), 1'b1, 1'b1);
    n++;
    checks++;
    if (bv8 !== 1'b0) begin
      errors++;
      $display("FAIL sync_at_end got vld=%b exp 0", bv8);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < SYM; i++) begin
      drive((i % 2 == 0) ? MID + 400 : MID - 400, 1'b1, 1'b0);
    end
    checks++;
    if (bv4 !== 1'b1 || zc4 !== 4'd15 || zc8 !== 8'd63 || bo4 !== 1'b0 || bad4 !== 1'b0) begin
      errors++;
      $display("FAIL saturation got vld=%b zc4=%0d zc8=%0d bit=%b bad=%b exp 1 15 63 0 0",
               bv4, zc4, zc8, bo4, bad4);
    end
    for (int i = 0; i < 40; i++) begin
      drive((i % 2 == 0) ? MID + 400 : MID - 400, 1'b1, 1'b0);
    end
    rst = 1'b1;
    drive(MID + 400, 1'b1, 1'b0);
    rst = 1'b0;
    checks++;
    if ({bo8, bv8, zc8, bad8, bo4, bv4, zc4, bad4} !== '0) begin
      errors++;
      $display("FAIL rst_mid_window got %b%b%0d%b %b%b%0d%b exp all 0",
               bo8, bv8, zc8, bad8, bo4, bv4, zc4, bad4);
    end
  endtask

  initial begin
    test_reset();
    test_tone(8, 16, 1'b0);
    test_tone(32, 4, 1'b1);
    test_noise();
    test_vld_gaps();
    test_sym_sync();
    test_saturation();
    drive(MID, 1'b0, 1'b0);
    drive(MID, 1'b0, 1'b0);
    checks++;
    if (q8.size() != 0 || q4.size() != 0) begin
      errors++;
      $display("FAIL sb_drain pending8=%0d pending4=%0d exp 0 0", q8.size(), q4.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
